hazard_ctrl: RTL

- Back-pressure and flush controller for the five-stage pipeline.
- Watches the instruction leaving ID and the instruction held in the ID/EX register.
- Drives stall, flush and bubble controls back into PC, IF/ID and ID/EX, so ID/EX only ever captures a legal instruction.
- Tracks in-flight destination registers through MEM/WB internally. Keeps saturating stall and flush event counters.

---
 rtl/hazard_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: detects RAW hazards between ID and in-flight producers,
// sequences the post-redirect flush window and counts stall / redirect events.
module hazard_ctrl #(
   parameter bit FWD_EN    = 1'b0,
   parameter int FLUSH_LEN = 2,
   parameter int CNT_W     = 32
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_rs1_used,
   input  logic             id_rs2_used,
   input  logic             id_valid,
   input  logic             ex_valid,
   input  logic [4:0]       ex_rd,
   input  logic [1:0]       ex_wb_select,
   input  logic             ex_pc_sel,
   output logic             pc_stall,
   output logic             if_id_stall,
   output logic             if_id_flush,
   output logic             id_ex_valid,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   typedef enum logic {RUN, FLUSH} state_t;

   localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_LEN - 1);

   state_t     state;
   logic [2:0] flush_cnt;
   logic [4:0] mem_rd;
   logic [4:0] wb_rd;
   logic       ex_writes;
   logic       ex_blocks;
   logic       rs1_hit;
   logic       rs2_hit;
   logic       hazard;
   logic       redirect;
   logic       flushing;
   logic       unused_wb;

   // With forwarding only a load in EX is too late for ID; MEM results are always forwarded.
   assign ex_writes = ex_valid && (ex_wb_select != 2'b11);
   assign ex_blocks = ex_writes && (!FWD_EN || (ex_wb_select == 2'b01));

   assign rs1_hit = (id_rs1 != 5'd0) &&
                    ((ex_blocks && (id_rs1 == ex_rd)) || (!FWD_EN && (id_rs1 == mem_rd)));
   assign rs2_hit = (id_rs2 != 5'd0) &&
                    ((ex_blocks && (id_rs2 == ex_rd)) || (!FWD_EN && (id_rs2 == mem_rd)));

   assign hazard   = id_valid && ((id_rs1_used && rs1_hit) || (id_rs2_used && rs2_hit));
   assign redirect = ex_valid && ex_pc_sel;
   assign flushing = redirect || (state == FLUSH);

   assign pc_stall    = !sys_rst && hazard && !flushing;
   assign if_id_stall = pc_stall;
   assign if_id_flush = !sys_rst && flushing;
   assign id_ex_valid = !sys_rst && id_valid && !flushing && !hazard;

   // The write-first register file makes wb_rd irrelevant for hazards; it is kept for debug.
   assign unused_wb = ^wb_rd;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state     <= RUN;
         flush_cnt <= 3'd0;
         mem_rd    <= 5'd0;
         wb_rd     <= 5'd0;
      end else begin
         mem_rd <= ex_writes ? ex_rd : 5'd0;
         wb_rd  <= mem_rd;
         case (state)
            RUN: begin
               if (redirect && (FLUSH_LEN > 1)) begin
                  state     <= FLUSH;
                  flush_cnt <= FLUSH_RELOAD;
               end
            end
            FLUSH: begin
               if (redirect) begin
                  flush_cnt <= FLUSH_RELOAD;
               end else if (flush_cnt == 3'd1) begin
                  state     <= RUN;
                  flush_cnt <= 3'd0;
               end else begin
                  flush_cnt <= flush_cnt - 3'd1;
               end
            end
            default: begin
               state     <= RUN;
               flush_cnt <= 3'd0;
            end
         endcase
      end
   end

   // Event counters stick at all-ones instead of wrapping.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         if (pc_stall && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
         end
         if (redirect && (flush_count != '1)) begin
            flush_count <= flush_count + CNT_W'(1);
         end
      end
   end

endmodule
